// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator: opcodes, sequencer states and
// the default pass-count ceiling.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int MAX_PASSES_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/pass_counter.sv
// 3-bit loadable down-counter; last_o flags the final pass of an operation.
module pass_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic       last_o
);

  logic [2:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         count_q <= 3'd0;
    else if (load_i)                 count_q <= load_val_i;
    else if (dec_i && count_q != 0)  count_q <= count_q - 3'd1;
  end

  assign last_o = (count_q == 3'd1);

endmodule

// File: rtl/arith_sequencer.sv
// Sequences the add/sub/mul/div datapath: latches operands, runs 1..N passes
// feeding the result back into z, then holds result and sticky flags.
module arith_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_PASSES = MAX_PASSES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] z_in,
  input  logic [2:0] passes,
  output logic [3:0] dp_x,
  output logic [3:0] dp_y,
  output logic [3:0] dp_ynot,
  output logic [7:0] dp_z,
  output logic [1:0] dp_op,
  input  logic [7:0] dp_result,
  input  logic       dp_as_ovf,
  input  logic [1:0] dp_md_ovf,
  output logic [7:0] result,
  output logic       as_ovf,
  output logic [1:0] md_ovf,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] MAX_P = 3'(MAX_PASSES);

  state_e     state_q, state_d;
  logic [3:0] dp_x_q, dp_y_q, dp_ynot_q;
  logic [7:0] dp_z_q, result_q;
  logic [1:0] dp_op_q, md_ovf_q;
  logic       as_ovf_q;
  logic       load, dec, capture, feed, last;
  logic [2:0] eff_passes, load_val;

  // Zero passes means one; anything above the ceiling is clamped.
  always_comb begin
    eff_passes = passes;
    if (passes == 3'd0)     eff_passes = 3'd1;
    else if (passes > MAX_P) eff_passes = MAX_P;
    load_val = op[1] ? eff_passes : 3'd1;
  end

  pass_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .dec_i      (dec),
    .last_o     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    capture = 1'b0;
    feed    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        // Abort outranks completion and leaves result/flags untouched.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          dec     = 1'b1;
          capture = 1'b1;
          if (last) state_d = ST_DONE;
          else      feed    = 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drive registers only move on load and z feedback so the display is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_op_q   <= 2'b00;
      dp_x_q    <= 4'd0;
      dp_y_q    <= 4'd0;
      dp_ynot_q <= 4'd0;
      dp_z_q    <= 8'd0;
    end else if (load) begin
      dp_op_q   <= op;
      dp_x_q    <= a;
      dp_y_q    <= b;
      dp_ynot_q <= ~b + 4'd1;
      dp_z_q    <= z_in;
    end else if (feed) begin
      dp_z_q    <= dp_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 8'd0;
      as_ovf_q <= 1'b0;
      md_ovf_q <= 2'b00;
    end else if (load) begin
      as_ovf_q <= 1'b0;
      md_ovf_q <= 2'b00;
    end else if (capture) begin
      result_q <= dp_result;
      as_ovf_q <= as_ovf_q | dp_as_ovf;
      md_ovf_q <= md_ovf_q | dp_md_ovf;
    end
  end

  assign dp_x    = dp_x_q;
  assign dp_y    = dp_y_q;
  assign dp_ynot = dp_ynot_q;
  assign dp_z    = dp_z_q;
  assign dp_op   = dp_op_q;
  assign result  = result_q;
  assign as_ovf  = as_ovf_q;
  assign md_ovf  = md_ovf_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Bench for arith_sequencer: stub datapath, directed table, random ops against
// an arithmetic reference, plus reset/abort/back-to-back sequences.
module tb_arith_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic [7:0] z_in = 8'd0;
  logic [2:0] passes = 3'd0;
  logic [3:0] dp_x, dp_y, dp_ynot;
  logic [7:0] dp_z, dp_result, result;
  logic [1:0] dp_op, dp_md_ovf, md_ovf;
  logic       dp_as_ovf, as_ovf, busy, done;

  int checks = 0, errors = 0;

  arith_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .a(a), .b(b),
    .z_in(z_in), .passes(passes), .dp_x(dp_x), .dp_y(dp_y), .dp_ynot(dp_ynot),
    .dp_z(dp_z), .dp_op(dp_op), .dp_result(dp_result), .dp_as_ovf(dp_as_ovf),
    .dp_md_ovf(dp_md_ovf), .result(result), .as_ovf(as_ovf), .md_ovf(md_ovf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Combinational datapath stand-in: 4-bit add of x with y or ynot, shift z.
  logic [4:0] s;
  logic [3:0] yy;
  always_comb begin
    yy        = (dp_op == OP_SUB) ? dp_ynot : dp_y;
    s         = {1'b0, dp_x} + {1'b0, yy};
    dp_result = 8'd0;
    dp_as_ovf = 1'b0;
    dp_md_ovf = 2'b00;
    case (dp_op)
      OP_MUL: begin dp_result = {dp_z[6:0], 1'b0}; dp_md_ovf = {dp_z[7], 1'b0}; end
      OP_DIV: begin dp_result = {1'b0, dp_z[7:1]}; dp_md_ovf = {1'b0, dp_z[0]}; end
      default: begin
        dp_result = {4'd0, s[3:0]};
        dp_as_ovf = (dp_x[3] == yy[3]) && (s[3] != dp_x[3]);
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " dp"}, {dp_x, dp_y, dp_ynot, dp_z, dp_op}, 32'd0);
    chk({name, " res"}, {result, as_ovf, md_ovf, busy, done}, 32'd0);
  endtask

  // Reference: operation as plain arithmetic over the effective pass count.
  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic model(input logic [1:0] o, input int ia, ib, iz, ip,
                       output int r, ovf, md, n, zlast);
    int sb, sum;
    n = (o >= 2) ? ((ip == 0) ? 1 : ip) : 1;
    r = 0; ovf = 0; md = 0; zlast = iz;
    if (o == OP_ADD || o == OP_SUB) begin
      sb  = (o == OP_SUB) ? sgn4((16 - ib) % 16) : sgn4(ib);
      sum = sgn4(ia) + sb;
      r   = (sum + 16) % 16;
      ovf = (sum < -8 || sum > 7) ? 1 : 0;
    end else if (o == OP_MUL) begin
      r     = (iz * (1 << n)) % 256;
      md    = ((iz >> (8 - n)) != 0) ? 2 : 0;
      zlast = (iz * (1 << (n - 1))) % 256;
    end else begin
      r     = iz / (1 << n);
      md    = ((iz % (1 << n)) != 0) ? 1 : 0;
      zlast = iz / (1 << (n - 1));
    end
  endtask

  // Issue one op; lat = edges after E0 until done is seen (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [3:0] ia, ib,
                        input logic [7:0] iz, input logic [2:0] ip, output int lat);
    @(negedge clk);
    op = o; a = ia; b = ib; z_in = iz; passes = ip; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin lat = k; break; end
    end
  endtask

  typedef struct {
    logic [1:0] o; logic [3:0] a, b; logic [7:0] z; logic [2:0] p;
    logic [7:0] r; logic ovf; logic [1:0] md; int lat; logic [3:0] ynot;
  } vec_t;

  vec_t vt[12];
  int lat, r, ovf, md, n, zl, cnt;

  initial begin
    vt[0]  = '{OP_ADD, 4'd3, 4'd4, 8'h00, 3'd0, 8'h07, 1'b0, 2'b00, 1, 4'hC};
    vt[1]  = '{OP_SUB, 4'd4, 4'd3, 8'h00, 3'd0, 8'h01, 1'b0, 2'b00, 1, 4'hD};
    vt[2]  = '{OP_ADD, 4'd7, 4'd1, 8'h00, 3'd5, 8'h08, 1'b1, 2'b00, 1, 4'hF};
    vt[3]  = '{OP_SUB, 4'd0, 4'd8, 8'h00, 3'd0, 8'h08, 1'b0, 2'b00, 1, 4'h8};
    vt[4]  = '{OP_SUB, 4'd8, 4'd1, 8'h00, 3'd0, 8'h07, 1'b1, 2'b00, 1, 4'hF};
    vt[5]  = '{OP_SUB, 4'd5, 4'd0, 8'h00, 3'd0, 8'h05, 1'b0, 2'b00, 1, 4'h0};
    vt[6]  = '{OP_MUL, 4'd0, 4'd0, 8'h03, 3'd3, 8'h18, 1'b0, 2'b00, 3, 4'h0};
    vt[7]  = '{OP_DIV, 4'd0, 4'd0, 8'h0D, 3'd2, 8'h03, 1'b0, 2'b01, 2, 4'h0};
    vt[8]  = '{OP_MUL, 4'd0, 4'd0, 8'h81, 3'd0, 8'h02, 1'b0, 2'b10, 1, 4'h0};
    vt[9]  = '{OP_MUL, 4'd0, 4'd0, 8'h81, 3'd1, 8'h02, 1'b0, 2'b10, 1, 4'h0};
    vt[10] = '{OP_MUL, 4'd0, 4'd0, 8'hFF, 3'd7, 8'h80, 1'b0, 2'b10, 7, 4'h0};
    vt[11] = '{OP_DIV, 4'd0, 4'd0, 8'h80, 3'd7, 8'h01, 1'b0, 2'b00, 7, 4'h0};

    repeat (3) @(negedge clk);
    chk_zero("reset held");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset released");

    foreach (vt[i]) begin
      run_op(vt[i].o, vt[i].a, vt[i].b, vt[i].z, vt[i].p, lat);
      chk($sformatf("v%0d lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d res", i), {result, as_ovf, md_ovf}, {vt[i].r, vt[i].ovf, vt[i].md});
      chk($sformatf("v%0d busy", i), busy, 1);
      if (vt[i].o < 2) chk($sformatf("v%0d ynot", i), dp_ynot, vt[i].ynot);
      @(negedge clk);
      chk($sformatf("v%0d after", i), {busy, done}, 2'b00);
    end

    // dp_z feedback sequence of a 3-pass multiply.
    @(negedge clk);
    op = OP_MUL; z_in = 8'h03; passes = 3'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk("mul z0", dp_z, 8'h03);
    @(negedge clk); chk("mul z1", dp_z, 8'h06);
    @(negedge clk); chk("mul z2", dp_z, 8'h0C);
    @(negedge clk); chk("mul done", {done, result}, {1'b1, 8'h18});

    // Start asserted during DONE is refused; accepted in the next IDLE cycle.
    op = OP_ADD; a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); chk("b2b idle", busy, 0);
    @(negedge clk); start = 1'b0; chk("b2b accept", {busy, dp_x, dp_y}, {1'b1, 4'd1, 4'd1});
    @(negedge clk); chk("b2b done", {done, result}, {1'b1, 8'h02});

    // start with abort in IDLE: abort wins.
    @(negedge clk);
    op = OP_SUB; a = 4'd9; start = 1'b1; abort = 1'b1;
    @(negedge clk); chk("idle abort", {busy, dp_x}, {1'b0, 4'd1});
    start = 1'b0; abort = 1'b0;

    // Abort in the 2nd EXEC cycle of a 4-pass mul; start while busy ignored.
    @(negedge clk);
    op = OP_MUL; z_in = 8'h05; passes = 3'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk); abort = 1'b1; start = 1'b1; z_in = 8'h07;
    @(negedge clk);
    chk("abort state", {busy, done}, 2'b00);
    chk("abort hold", {result, md_ovf}, {8'h0A, 2'b00});
    abort = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("restart", {busy, dp_z}, {1'b1, 8'h07});
    cnt = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin cnt = k; break; end
    end
    chk("restart done", {cnt, result}, {32'd4, 8'h70});

    // Reset in the middle of a 5-pass multiply.
    @(negedge clk);
    op = OP_MUL; z_in = 8'h01; passes = 3'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk_zero("mid reset");
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (8) @(negedge clk) if (done || busy) cnt++;
    chk("no done after reset", cnt, 0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] ro; logic [3:0] ra, rb; logic [7:0] rz; logic [2:0] rp;
      ro = 2'($urandom_range(0, 3)); ra = 4'($urandom); rb = 4'($urandom);
      rz = 8'($urandom); rp = 3'($urandom);
      model(ro, ra, rb, rz, rp, r, ovf, md, n, zl);
      run_op(ro, ra, rb, rz, rp, lat);
      chk($sformatf("rnd%0d lat", t), lat, n);
      chk($sformatf("rnd%0d res", t), {result, as_ovf, md_ovf},
          {r[7:0], ovf[0], md[1:0]});
      chk($sformatf("rnd%0d drv", t), {dp_op, dp_x, dp_y, dp_z},
          {ro, ra, rb, zl[7:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
